// File: rtl/branch_pkg.sv
// branch_pkg: shared state encoding and default parameters for the branch redirect controller
package branch_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  localparam int DEF_NUM_SLOTS = 2;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: branch results and fetch redirect handshake bundle
interface branch_redirect_ctrl_if
  import branch_pkg::*;
#(parameter int NUM_SLOTS = DEF_NUM_SLOTS);
  logic [NUM_SLOTS-1:0] br_valid;
  logic [NUM_SLOTS-1:0] br_taken;
  logic [NUM_SLOTS-1:0][31:0] br_target;
  logic fetch_ready;
  logic issue_stall;
  logic flush;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic misalign_err;
  logic [15:0] taken_count;
  modport master (
    output br_valid, br_taken, br_target, fetch_ready,
    input issue_stall, flush, redirect_valid, redirect_pc, misalign_err, taken_count
  );
  modport slave (
    input br_valid, br_taken, br_target, fetch_ready,
    output issue_stall, flush, redirect_valid, redirect_pc, misalign_err, taken_count
  );
endinterface

// File: rtl/branch_slot_prio.sv
// branch_slot_prio: picks the oldest (lowest-index) qualifying slot as a one-hot winner
module branch_slot_prio #(
  parameter int NUM_SLOTS = 2
) (
  input  logic [NUM_SLOTS-1:0] qual,
  output logic [NUM_SLOTS-1:0] winner,
  output logic                 any
);
  assign winner = qual & (~qual + NUM_SLOTS'(1));
  assign any = |qual;
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns the oldest taken branch of a bundle into a flush followed by a fetch redirect
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int          NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter logic [31:0] TRAP_VEC     = DEF_TRAP_VEC
) (
  input logic clk,
  input logic rst,
  branch_redirect_ctrl_if.slave bus
);
  state_t state;
  logic [3:0] cnt;
  logic [15:0] count;
  logic [NUM_SLOTS-1:0] winner;
  logic any;
  logic [31:0] target;
  logic misaligned;
  logic flush_q, rv_q, stall_q, mis_q;
  logic [31:0] pc_q;
  branch_slot_prio #(.NUM_SLOTS(NUM_SLOTS)) u_prio (
    .qual(bus.br_valid & bus.br_taken),
    .winner(winner),
    .any(any)
  );
  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_SLOTS; i++) target |= winner[i] ? bus.br_target[i] : 32'h0;
  end
  assign misaligned = target[1:0] != 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      count   <= '0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      stall_q <= 1'b0;
      mis_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      mis_q <= 1'b0;
      unique case (state)
        IDLE: if (any) begin
          state   <= FLUSH;
          flush_q <= 1'b1;
          stall_q <= 1'b1;
          cnt     <= 4'(FLUSH_CYCLES);
          pc_q    <= misaligned ? TRAP_VEC : target;
          mis_q   <= misaligned;
        end
        FLUSH: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= REDIRECT;
            flush_q <= 1'b0;
            rv_q    <= 1'b1;
          end
        end
        REDIRECT: if (bus.fetch_ready) begin
          state   <= IDLE;
          rv_q    <= 1'b0;
          stall_q <= 1'b0;
          count   <= count == 16'hFFFF ? count : count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.issue_stall    = stall_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = pc_q;
  assign bus.misalign_err   = mis_q;
  assign bus.taken_count    = count;
endmodule
